// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges 1-cycle ALU results with buffered memory results into one registered regfile write per cycle.
// Latency ALU 1 cycle, memory 2+ cycles; memory backpressured only by a full 2-entry buffer, ALU is never stalled.
module wb_arbiter #(
    parameter int N = 32,
    parameter int W = 32,
    localparam int A = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_valid,
    input  logic [A-1:0] alu_rd,
    input  logic [W-1:0] alu_data,
    input  logic         mem_valid,
    output logic         mem_ready,
    input  logic [A-1:0] mem_rd,
    input  logic [W-1:0] mem_data,
    output logic         wen,
    output logic [A-1:0] waddr,
    output logic [W-1:0] wdata,
    output logic [1:0]   buf_count
);

    logic [A-1:0] rd_q   [2];
    logic [A-1:0] rd_d   [2];
    logic [W-1:0] data_q [2];
    logic [W-1:0] data_d [2];
    logic [1:0]   live_q;
    logic [1:0]   live_d;
    logic         head_q, head_d;
    logic [1:0]   count_q, count_d;
    logic         wen_q, wen_d;
    logic [A-1:0] waddr_q, waddr_d;
    logic [W-1:0] wdata_q, wdata_d;

    logic alu_eff, mem_acc, push, pop, head_live, tail;

    assign mem_ready = (count_q != 2'd2);

    always_comb begin
        alu_eff   = alu_valid && (alu_rd != '0);
        mem_acc   = mem_valid && mem_ready;
        // Memory results are older than a concurrent ALU write, so a same-rd one is stale on arrival.
        push      = mem_acc && (mem_rd != '0) && !(alu_eff && (mem_rd == alu_rd));
        head_live = (count_q != 2'd0) && live_q[head_q];
        // Dead heads drain regardless of the ALU; live heads only when the port is free.
        pop       = (count_q != 2'd0) && (!live_q[head_q] || !alu_eff);
        tail      = head_q ^ (count_q == 2'd1);

        rd_d   = rd_q;
        data_d = data_q;
        live_d = live_q;
        for (int i = 0; i < 2; i++) begin
            if (alu_eff && (rd_q[i] == alu_rd)) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
        if (push) begin
            rd_d[tail]   = mem_rd;
            data_d[tail] = mem_data;
            live_d[tail] = 1'b1;
        end
        head_d  = head_q ^ pop;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_eff) begin
            wen_d   = 1'b1;
            waddr_d = alu_rd;
            wdata_d = alu_data;
        end else if (head_live) begin
            wen_d   = 1'b1;
            waddr_d = rd_q[head_q];
            wdata_d = data_q[head_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            live_q  <= '0;
            head_q  <= 1'b0;
            count_q <= 2'd0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rd_q    <= rd_d;
            data_q  <= data_d;
            live_q  <= live_d;
            head_q  <= head_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wen       = wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign buf_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based model predicts writes and buffer occupancy per cycle.
module tb_wb_arbiter;

    localparam int N = 32;
    localparam int W = 32;
    localparam int A = $clog2(N);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         alu_valid = 1'b0;
    logic [A-1:0] alu_rd = '0;
    logic [W-1:0] alu_data = '0;
    logic         mem_valid = 1'b0;
    logic         mem_ready;
    logic [A-1:0] mem_rd = '0;
    logic [W-1:0] mem_data = '0;
    logic         wen;
    logic [A-1:0] waddr;
    logic [W-1:0] wdata;
    logic [1:0]   buf_count;

    wb_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wen(wen), .waddr(waddr), .wdata(wdata), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [A-1:0] rd;
        logic [W-1:0] data;
        bit           live;
    } ent_t;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    typedef struct {
        int           cnt;
        bit           rdy;
        bit           wen;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } st_t;

    ent_t mq[$];
    wr_t  wq[$];
    st_t  sq[$];
    logic [A-1:0] m_addr = '0;
    logic [W-1:0] m_data = '0;
    bit   mon_en = 0;
    int   errs = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives one cycle of inputs, predicts its outcome, returns at the next negedge.
    task automatic step(input bit av, input logic [A-1:0] ard, input logic [W-1:0] adat,
                        input bit mv, input logic [A-1:0] mrd, input logic [W-1:0] mdat);
        bit   eff, acc, wr;
        st_t  s;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;

        eff = av && (ard != 0);
        acc = mv && (mq.size() < 2);
        wr  = 0;
        if (mq.size() > 0 && !mq[0].live) begin
            void'(mq.pop_front());
        end else if (!eff && mq.size() > 0) begin
            wr = 1; m_addr = mq[0].rd; m_data = mq[0].data;
            void'(mq.pop_front());
        end
        if (eff) begin
            wr = 1; m_addr = ard; m_data = adat;
            foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 0;
        end
        if (acc && mrd != 0 && !(eff && mrd == ard)) mq.push_back('{rd: mrd, data: mdat, live: 1});
        if (wr) wq.push_back('{addr: m_addr, data: m_data});
        s.cnt = mq.size(); s.rdy = (mq.size() < 2); s.wen = wr; s.addr = m_addr; s.data = m_data;
        sq.push_back(s);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sq.size() == 0) begin
                    chk("status_underflow", 1, 0);
                end else begin
                    s = sq.pop_front();
                    chk("buf_count", 32'(buf_count), 32'(s.cnt));
                    chk("mem_ready", 32'(mem_ready), 32'(s.rdy));
                    chk("wen", 32'(wen), 32'(s.wen));
                    chk("waddr_held", 32'(waddr), 32'(s.addr));
                    chk("wdata_held", wdata, s.data);
                    if (wen) begin
                        if (wq.size() == 0) begin
                            chk("unexpected_write", 32'(waddr), 32'hFFFF_FFFF);
                        end else begin
                            w = wq.pop_front();
                            chk("wr_addr", 32'(waddr), 32'(w.addr));
                            chk("wr_data", wdata, w.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_wen", 32'(wen), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_count", 32'(buf_count), 0);
        chk("rst_ready", 32'(mem_ready), 1);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready_held", 32'(mem_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;

        step(1, 1, 32'hA5A5_A5A5, 0, 0, 0);
        step(0, 0, 0, 1, 2, 32'h5A5A_5A5A);
        idle(2);
        step(1, 5, 32'h5555_0005, 1, 3, 32'h3333_3333);
        step(1, 6, 32'h6666_0006, 1, 4, 32'h4444_4444);
        step(1, 7, 32'h7777_0007, 1, 9, 32'h9999_9999);
        idle(3);
        step(0, 0, 0, 1, 8, 32'h1111_1111);
        step(1, 8, 32'h2222_2222, 0, 0, 0);
        idle(2);
        step(1, 0, 32'hDEAD_BEEF, 1, 0, 32'hBEEF_DEAD);
        step(1, 10, 32'h0000_00AA, 1, 10, 32'h0000_00BB);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            logic [A-1:0] ar, mr;
            ar = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 3));
            mr = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 3));
            step(($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 40 : 85)), ar, $urandom,
                 ($urandom_range(0, 99) < 60), mr, $urandom);
        end
        idle(4);
        chk("writes_drained", wq.size(), 0);

        // Fill the buffer under ALU pressure, then hit reset mid-cycle with a write on the port.
        step(1, 5, 32'hC0DE_0005, 1, 3, 32'hC0DE_0003);
        step(1, 6, 32'hC0DE_0006, 1, 4, 32'hC0DE_0004);
        mon_en = 0;
        chk("pre_rst_count", 32'(buf_count), 2);
        chk("pre_rst_wen", 32'(wen), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wen", 32'(wen), 0);
        chk("mid_rst_waddr", 32'(waddr), 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_count", 32'(buf_count), 0);
        chk("mid_rst_ready", 32'(mem_ready), 1);
        mq.delete(); wq.delete(); sq.delete();
        m_addr = '0; m_data = '0;
        alu_valid = 0; mem_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;
        idle(5);
        mon_en = 0;
        chk("final_writes_empty", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
